// File: rtl/timer_sched_pkg.sv
// Shared types and register map for the timer delay scheduler.
// Offsets and CTRL fields mirror the APB timer's register layout.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_STOP,
        ST_WR_CMP,
        ST_WR_START,
        ST_WAIT,
        ST_WR_HALT,
        ST_DONE
    } sched_state_e;

    localparam logic [7:0] TMR_OFF_TIMER = 8'h0;
    localparam logic [7:0] TMR_OFF_CTRL  = 8'h4;
    localparam logic [7:0] TMR_OFF_CMP   = 8'h8;

    localparam int ENABLE_BIT = 0;
    localparam int PRESC_LSB  = 3;
    localparam int PRESC_MSB  = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at NUM_REQ (which need not be a power of two).
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       vld
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    // Scan farthest-first so the nearest requester after ptr overwrites last.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        sum = '0;
        k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ))
                sum = sum - (IW+1)'(NUM_REQ);
            k = sum[IW-1:0];
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = k;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_delay_sched.sv
// Shares one APB timer among NUM_REQ one-shot delay requesters: arbitrates,
// programs stop/cmp/start over APB, waits for the compare irq, then halts.
module timer_delay_sched
    import timer_sched_pkg::*;
#(
    parameter int                        NUM_REQ        = 4,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] TIMER_BASE     = '0,
    parameter logic [2:0]                PRESCALER      = 3'd0
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*32-1:0]     delay_i,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic [1:0]                irq_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL = TIMER_BASE + APB_ADDR_WIDTH'(TMR_OFF_CTRL);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CMP  = TIMER_BASE + APB_ADDR_WIDTH'(TMR_OFF_CMP);

    sched_state_e       state_q, state_d;
    logic               phase_q, phase_d;   // 0: SETUP, 1: ACCESS
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic [IW-1:0]      g_q, g_d, ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [31:0]        dly_q, dly_d;
    logic [31:0]        ctrl_start;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_vld;
    logic               wr_state;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign wr_state = (state_q == ST_WR_STOP) || (state_q == ST_WR_CMP) ||
                      (state_q == ST_WR_START) || (state_q == ST_WR_HALT);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            g_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dly_q   <= dly_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ok_d    = ok_q;
        err_d   = 1'b0;
        g_d     = g_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dly_d   = dly_q;
        case (state_q)
            ST_IDLE: if (|req_i) state_d = ST_ARB;
            ST_ARB: begin
                ok_d = 1'b0;
                if (arb_vld) begin
                    g_d     = arb_idx;
                    gnt_d   = arb_gnt;
                    dly_d   = delay_i[32*arb_idx +: 32];
                    // cmp=0 would never fire, so finish without touching the bus
                    state_d = (delay_i[32*arb_idx +: 32] == '0) ? ST_DONE : ST_WR_STOP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_STOP, ST_WR_CMP, ST_WR_START, ST_WR_HALT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (PREADY) begin
                    phase_d = 1'b0;
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        ok_d    = 1'b0;
                        state_d = (state_q == ST_WR_HALT) ? ST_IDLE : ST_WR_HALT;
                    end else begin
                        case (state_q)
                            ST_WR_STOP:  state_d = ST_WR_CMP;
                            ST_WR_CMP:   state_d = ST_WR_START;
                            ST_WR_START: state_d = ST_WAIT;
                            default:     state_d = ok_q ? ST_DONE : ST_IDLE;
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                if (irq_i[1]) begin
                    ok_d    = 1'b1;
                    state_d = ST_WR_HALT;
                end else if (!(|(req_i & gnt_q))) begin
                    ok_d    = 1'b0;
                    state_d = ST_WR_HALT;
                end else if (irq_i[0]) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_WR_HALT;
                end
            end
            ST_DONE: begin
                ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_start                      = '0;
        ctrl_start[ENABLE_BIT]          = 1'b1;
        ctrl_start[PRESC_MSB:PRESC_LSB] = PRESCALER;
        PADDR  = '0;
        PWDATA = '0;
        case (state_q)
            ST_WR_STOP, ST_WR_HALT: PADDR = A_CTRL;
            ST_WR_CMP: begin
                PADDR  = A_CMP;
                PWDATA = dly_q;
            end
            ST_WR_START: begin
                PADDR  = A_CTRL;
                PWDATA = ctrl_start;
            end
            default: ;
        endcase
    end

    assign PSEL    = wr_state;
    assign PENABLE = wr_state && phase_q;
    assign PWRITE  = wr_state;
    assign done_o  = (state_q == ST_DONE) ? gnt_q : '0;
    assign busy_o  = (state_q != ST_IDLE);
    assign err_o   = err_q;

endmodule

// File: tb/tb_timer_delay_sched.sv
// Directed bench for timer_delay_sched with a small behavioural APB timer.
module tb_timer_delay_sched;
    localparam int N = 4;

    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*32-1:0] delay_i = '0;
    logic [N-1:0]    done_o;
    logic            busy_o, err_o;
    logic [11:0]     PADDR;
    logic [31:0]     PWDATA;
    logic            PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [1:0]      irq_i;

    always #5 HCLK = ~HCLK;

    timer_delay_sched #(.NUM_REQ(N), .APB_ADDR_WIDTH(12), .TIMER_BASE(12'h0), .PRESCALER(3'd0)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .delay_i(delay_i),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_i(irq_i)
    );

    // Timer slave model and bus/event monitors
    logic        t_en = 1'b0;
    logic [31:0] t_cnt = '0, t_cmp = '0;
    logic        force_ovf = 1'b0, err_arm = 1'b0, ws_en = 1'b0;
    logic [11:0] err_addr = 12'h8;
    int          ws_cnt = 0, err_cnt = 0, psel_cnt = 0, unstable = 0;
    logic [11:0] s_a = '0;
    logic [31:0] s_d = '0;
    logic [11:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          done_log[$];

    assign PREADY  = !ws_en || (ws_cnt >= 3);
    assign PSLVERR = err_arm && PSEL && PENABLE && PREADY && (PADDR == err_addr);
    assign irq_i   = {t_en && (t_cnt == t_cmp), force_ovf};

    always @(posedge HCLK) begin
        if (PSEL && PENABLE && !PREADY) ws_cnt <= ws_cnt + 1;
        else ws_cnt <= 0;
        if (PSEL && PENABLE && PREADY) begin
            wr_a.push_back(PADDR);
            wr_d.push_back(PWDATA);
            if (PADDR == 12'h4) t_en <= PWDATA[0];
            if (PADDR == 12'h8) begin
                t_cmp <= PWDATA;
                t_cnt <= '0;
            end
        end else if (t_en) begin
            t_cnt <= t_cnt + 1;
        end
        for (int i = 0; i < N; i++) if (done_o[i]) done_log.push_back(i);
        if (err_o) err_cnt <= err_cnt + 1;
        if (PSEL) psel_cnt <= psel_cnt + 1;
        if (PSEL && !PENABLE) begin
            s_a <= PADDR;
            s_d <= PWDATA;
        end else if (PSEL && PENABLE && (PADDR != s_a || PWDATA != s_d)) begin
            unstable <= unstable + 1;
        end
    end

    int n_chk = 0, n_pass = 0;
    int wb, db, eb, pb, n, idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        req_i = '0;
        force_ovf = 1'b0;
        err_arm = 1'b0;
        ws_en = 1'b0;
        tick(2);
        HRESET = 1'b0;
        wb = wr_a.size(); db = done_log.size(); eb = err_cnt; pb = psel_cnt;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            tick(1);
            if (!busy_o) break;
        end
        if (k == budget) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_writes(input string tag, input int cnt, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            tick(1);
            if (wr_a.size() - wb >= cnt) break;
        end
        if (k == budget) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_psel", {PSEL, PENABLE, PWRITE}, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);

        // Single request, delay 10; delay changed in flight must not matter
        delay_i[64 +: 32] = 32'd10;
        req_i = 4'b0100;
        n = 0;
        while (n < 60) begin
            tick(1);
            n++;
            if (n == 3) delay_i[64 +: 32] = 32'd77;
            if (done_o[2]) break;
        end
        chk("single_lat", n, 21);
        req_i = '0;
        tick(3);
        chk("single_nwr", wr_a.size() - wb, 4);
        chk("single_w0", {wr_a[wb], wr_d[wb]}, {12'h4, 32'h0});
        chk("single_w1", {wr_a[wb+1], wr_d[wb+1]}, {12'h8, 32'd10});
        chk("single_w2", {wr_a[wb+2], wr_d[wb+2]}, {12'h4, 32'h1});
        chk("single_w3", {wr_a[wb+3], wr_d[wb+3]}, {12'h4, 32'h0});
        chk("single_ndone", done_log.size() - db, 1);
        chk("single_idle", busy_o, 0);

        // Round-robin fairness, two rounds
        do_reset();
        for (int i = 0; i < N; i++) delay_i[32*i +: 32] = 32'd3;
        req_i = 4'b1111;
        for (int r = 0; r < 8; r++) begin
            idx = -1;
            for (int k = 0; k < 100 && idx < 0; k++) begin
                tick(1);
                for (int i = 0; i < N; i++) if (done_o[i]) idx = i;
            end
            chk($sformatf("rr_order%0d", r), idx, r % N);
            if (idx >= 0) req_i[idx] = 1'b0;
            if (r == 3) begin
                tick(1);
                req_i = 4'b1111;
            end
        end
        tick(3);
        chk("rr_idle", busy_o, 0);

        // Zero delay: no bus traffic
        do_reset();
        delay_i[32 +: 32] = 32'd0;
        req_i = 4'b0010;
        n = 0;
        while (n < 3) begin
            tick(1);
            n++;
            if (done_o[1]) break;
        end
        chk("zero_done", done_o[1], 1);
        chk("zero_lat", n, 2);
        req_i = '0;
        tick(3);
        chk("zero_psel", psel_cnt - pb, 0);

        // Withdrawal in WAIT
        do_reset();
        delay_i[0 +: 32] = 32'd100;
        req_i = 4'b0001;
        wait_writes("wd", 3, 40);
        tick(10);
        chk("wd_busy_wait", busy_o, 1);
        req_i = '0;
        wait_idle("wd", 20);
        chk("wd_nwr", wr_a.size() - wb, 4);
        chk("wd_halt", {wr_a[wb+3], wr_d[wb+3]}, {12'h4, 32'h0});
        chk("wd_ndone", done_log.size() - db, 0);
        chk("wd_idle", busy_o, 0);

        // PSLVERR on CMP write
        do_reset();
        delay_i[0 +: 32] = 32'd5;
        err_addr = 12'h8;
        err_arm = 1'b1;
        req_i = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (err_o) req_i = '0;
            if (k > 2 && !busy_o) break;
        end
        err_arm = 1'b0;
        tick(2);
        chk("slverr_err", err_cnt - eb, 1);
        chk("slverr_nwr", wr_a.size() - wb, 3);
        chk("slverr_halt", {wr_a[wb+2], wr_d[wb+2]}, {12'h4, 32'h0});
        chk("slverr_ndone", done_log.size() - db, 0);
        chk("slverr_idle", busy_o, 0);

        // Overflow irq while waiting
        do_reset();
        delay_i[96 +: 32] = 32'd50;
        req_i = 4'b1000;
        wait_writes("ovf", 3, 40);
        tick(5);
        force_ovf = 1'b1;
        tick(1);
        force_ovf = 1'b0;
        req_i = '0;
        wait_idle("ovf", 20);
        tick(2);
        chk("ovf_err", err_cnt - eb, 1);
        chk("ovf_ndone", done_log.size() - db, 0);
        chk("ovf_halt", {wr_a[wb+3], wr_d[wb+3]}, {12'h4, 32'h0});

        // Wait states on every ACCESS
        do_reset();
        ws_en = 1'b1;
        delay_i[64 +: 32] = 32'd4;
        req_i = 4'b0100;
        n = 0;
        while (n < 200) begin
            tick(1);
            n++;
            if (done_o[2]) break;
        end
        chk("ws_done", done_o[2], 1);
        req_i = '0;
        tick(3);
        chk("ws_stable", unstable, 0);
        chk("ws_nwr", wr_a.size() - wb, 4);
        chk("ws_cmp", {wr_a[wb+1], wr_d[wb+1]}, {12'h8, 32'd4});
        ws_en = 1'b0;

        // Reset mid-WAIT
        do_reset();
        delay_i[32 +: 32] = 32'd100;
        req_i = 4'b0010;
        wait_writes("rw", 3, 40);
        tick(5);
        HRESET = 1'b1;
        req_i = '0;
        tick(1);
        chk("rw_busy", busy_o, 0);
        chk("rw_done_err", {done_o, err_o}, 0);
        chk("rw_apb", {PSEL, PENABLE, PWRITE}, 0);
        chk("rw_paddr", PADDR, 0);
        chk("rw_pwdata", PWDATA, 0);
        HRESET = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
